// File: rtl/async_fifo_w256_r8.sv
// Dual-clock FIFO, 256-bit write / 8-bit read. Word-granular pointers cross
// domains as registered Gray code through 2-flop synchronizers.
module async_fifo_w256_r8 #(
  parameter int WR_DEPTH_WIDTH   = 5,
  parameter int WR_DATA_WIDTH    = 256,
  parameter int RD_DEPTH_WIDTH   = 10,
  parameter int RD_DATA_WIDTH    = 8,
  parameter int ALMOST_FULL_NUM  = 28,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                      wr_clk,
  input  logic                      wr_rst,
  input  logic                      rd_clk,
  input  logic                      rd_rst,
  input  logic [WR_DATA_WIDTH-1:0]  wr_data,
  input  logic                      wr_en,
  output logic                      wr_full,
  output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
  output logic                      almost_full,
  output logic [RD_DATA_WIDTH-1:0]  rd_data,
  input  logic                      rd_en,
  output logic                      rd_empty,
  output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
  output logic                      almost_empty
);
  localparam int SEL_W = RD_DEPTH_WIDTH - WR_DEPTH_WIDTH;
  localparam int WP_W  = WR_DEPTH_WIDTH + 1;
  localparam int RP_W  = RD_DEPTH_WIDTH + 1;
  localparam int NB    = WR_DATA_WIDTH / RD_DATA_WIDTH;
  localparam int DEPTH = 1 << WR_DEPTH_WIDTH;

  function automatic logic [WP_W-1:0] bin2gray(input logic [WP_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WP_W-1:0] gray2bin(input logic [WP_W-1:0] g);
    logic [WP_W-1:0] b;
    b[WP_W-1] = g[WP_W-1];
    for (int i = WP_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [NB-1:0][RD_DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------- write domain ----------------
  logic [WP_W-1:0]         wr_ptr, wr_ptr_nxt, wr_gray, rd_bin_nxt, wr_level_nxt;
  logic [1:0][WP_W-1:0]    rd_gray_sync;
  logic [WP_W-1:0]         rd_gray;
  logic                    wr_ok;

  assign wr_ok        = wr_en & ~wr_full;
  assign wr_ptr_nxt   = wr_ptr + WP_W'(wr_ok);
  // Flags are computed from the value entering the last sync stage so they
  // update on the same edge as the pointer that moved them.
  assign rd_bin_nxt   = gray2bin(rd_gray_sync[0]);
  assign wr_level_nxt = wr_ptr_nxt - rd_bin_nxt;

  always_ff @(posedge wr_clk)
    if (wr_ok) mem[wr_ptr[WR_DEPTH_WIDTH-1:0]] <= wr_data;

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wr_ptr         <= '0;
      wr_gray        <= '0;
      rd_gray_sync   <= '0;
      wr_water_level <= '0;
      wr_full        <= 1'b0;
      almost_full    <= 1'b0;
    end else begin
      wr_ptr         <= wr_ptr_nxt;
      wr_gray        <= bin2gray(wr_ptr_nxt);
      rd_gray_sync   <= {rd_gray_sync[0], rd_gray};
      wr_water_level <= wr_level_nxt;
      wr_full        <= (wr_level_nxt == WP_W'(DEPTH));
      almost_full    <= (wr_level_nxt >= WP_W'(ALMOST_FULL_NUM));
    end
  end

  // ---------------- read domain ----------------
  logic [RP_W-1:0]         rd_ptr, rd_ptr_nxt, rd_level_nxt;
  logic [1:0][WP_W-1:0]    wr_gray_sync;
  logic [WP_W-1:0]         wr_bin_nxt;
  logic                    rd_ok;

  assign rd_ok        = rd_en & ~rd_empty;
  assign rd_ptr_nxt   = rd_ptr + RP_W'(rd_ok);
  assign wr_bin_nxt   = gray2bin(wr_gray_sync[0]);
  assign rd_level_nxt = {wr_bin_nxt, SEL_W'(0)} - rd_ptr_nxt;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_ptr         <= '0;
      rd_gray        <= '0;
      wr_gray_sync   <= '0;
      rd_water_level <= '0;
      rd_empty       <= 1'b1;
      almost_empty   <= 1'b1;
      rd_data        <= '0;
    end else begin
      rd_ptr         <= rd_ptr_nxt;
      // Only whole-word progress is sent back, so a partial word stays occupied.
      rd_gray        <= bin2gray(rd_ptr_nxt[RP_W-1:SEL_W]);
      wr_gray_sync   <= {wr_gray_sync[0], wr_gray};
      rd_water_level <= rd_level_nxt;
      rd_empty       <= (rd_level_nxt == '0);
      almost_empty   <= (rd_level_nxt <= RP_W'(ALMOST_EMPTY_NUM));
      if (rd_ok) rd_data <= mem[rd_ptr[RD_DEPTH_WIDTH-1:SEL_W]][rd_ptr[SEL_W-1:0]];
    end
  end
endmodule

// File: tb/tb_async_fifo_w256_r8.sv
// Self-checking bench: byte-queue reference model, directed fill/drain,
// randomized interleaved traffic and a mid-fill reset.
module tb_async_fifo_w256_r8;
  logic         clk = 1'b0;
  logic         tb_rst;
  logic [255:0] wr_data;
  logic         wr_en, rd_en;
  logic         wr_full, almost_full, rd_empty, almost_empty;
  logic [5:0]   wr_water_level;
  logic [10:0]  rd_water_level;
  logic [7:0]   rd_data;

  int errs   = 0;
  int checks = 0;
  logic [7:0] q[$];     // every byte stored, in read order
  logic [7:0] last;     // value rd_data must be holding

  always #5 clk = ~clk;

  async_fifo_w256_r8 dut (
    .wr_clk(clk), .wr_rst(tb_rst), .rd_clk(clk), .rd_rst(tb_rst),
    .wr_data(wr_data), .wr_en(wr_en), .wr_full(wr_full),
    .wr_water_level(wr_water_level), .almost_full(almost_full),
    .rd_data(rd_data), .rd_en(rd_en), .rd_empty(rd_empty),
    .rd_water_level(rd_water_level), .almost_empty(almost_empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_le(input string tag, input int lo, input int hi);
    checks++;
    assert (lo <= hi) else begin
      errs++;
      $error("FAIL %s: value=%0d exceeds bound=%0d", tag, lo, hi);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [255:0] w);
    for (int k = 0; k < 32; k++) q.push_back(w[8*k +: 8]);
  endtask

  function automatic int occ_words();
    return (q.size() + 31) / 32;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rd_empty"}, rd_empty, 1);
    chk({tag, "_almost_empty"}, almost_empty, 1);
    chk({tag, "_wr_full"}, wr_full, 0);
    chk({tag, "_almost_full"}, almost_full, 0);
    chk({tag, "_wr_level"}, wr_water_level, 0);
    chk({tag, "_rd_level"}, rd_water_level, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
  endtask

  task automatic chk_settled(input string tag);
    chk({tag, "_wr_level"}, wr_water_level, occ_words());
    chk({tag, "_wr_full"}, wr_full, occ_words() == 32);
    chk({tag, "_rd_level"}, rd_water_level, q.size());
    chk({tag, "_rd_empty"}, rd_empty, q.size() == 0);
  endtask

  initial begin
    logic [255:0] w;
    logic [7:0]   byte32;
    bit           wacc, racc;
    int           wp[3] = '{20, 2, 4};
    int           rp[3] = '{60, 90, 100};
    int           guard;

    tb_rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0; last = '0; byte32 = '0;
    #200;
    step();
    chk_reset_state("reset");
    tb_rst = 1'b0;
    step();

    // 33 writes of a decrementing counter from all-ones; last one hits full
    for (int i = 0; i < 33; i++) begin
      w = '1;
      w = w - 256'(i);
      wr_en = 1'b1; wr_data = w;
      if (occ_words() < 32) push_word(w);
      step();
      chk("fill_wr_level", wr_water_level, occ_words());
      chk("fill_almost_full", almost_full, occ_words() >= 28);
      chk("fill_wr_full", wr_full, occ_words() == 32);
    end
    wr_en = 1'b0;
    repeat (5) step();
    chk("synced_rd_level", rd_water_level, 1024);
    chk("synced_rd_empty", rd_empty, 0);
    chk("synced_almost_empty", almost_empty, 0);

    // 1025 reads: the last one must be ignored with rd_data holding
    for (int i = 0; i < 1025; i++) begin
      rd_en = 1'b1;
      if (q.size() > 0) last = q.pop_front();
      step();
      if (i == 32) byte32 = rd_data;
      chk("drain_rd_data", rd_data, last);
      chk("drain_rd_level", rd_water_level, q.size());
      chk("drain_almost_empty", almost_empty, q.size() <= 4);
      chk("drain_rd_empty", rd_empty, q.size() == 0);
    end
    rd_en = 1'b0;
    chk("word1_byte0", byte32, 8'hFE);
    chk("last_byte_hold", rd_data, 8'hFF);
    repeat (5) step();
    chk("freed_wr_level", wr_water_level, 0);
    chk("freed_almost_full", almost_full, 0);

    // Randomized interleaved traffic; flags may lag, so bound them by the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int ph;
      ph = cyc / 1000;
      for (int k = 0; k < 8; k++) w[32*k +: 32] = $urandom;
      wr_en = ($urandom % 100) < wp[ph];
      rd_en = ($urandom % 100) < rp[ph];
      wr_data = w;
      wacc = wr_en && !wr_full;
      racc = rd_en && !rd_empty;
      if (racc) begin
        chk_le("rd_no_underflow", 1, q.size());
        if (q.size() > 0) last = q.pop_front();
      end
      if (wacc) begin
        push_word(w);
        chk_le("wr_no_overflow", occ_words(), 32);
      end
      step();
      chk("rand_rd_data", rd_data, last);
      chk_le("rand_wr_level_pessimistic", occ_words(), int'(wr_water_level));
      chk_le("rand_rd_level_pessimistic", int'(rd_water_level), q.size());
    end
    wr_en = 1'b0;

    // Drain whatever is left, bounded
    guard = 0;
    rd_en = 1'b1;
    while (q.size() > 0 && guard < 3000) begin
      racc = !rd_empty;
      if (racc) last = q.pop_front();
      step();
      if (racc) chk("tail_rd_data", rd_data, last);
      guard++;
    end
    rd_en = 1'b0;
    chk("tail_drained", q.size(), 0);
    repeat (6) step();
    chk_settled("after_random");

    // Reset in the middle of a fill
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 8; k++) w[32*k +: 32] = $urandom;
      wr_en = 1'b1; wr_data = w;
      push_word(w);
      step();
    end
    wr_en = 1'b0;
    step();
    chk("prefill_wr_level", wr_water_level, 10);
    tb_rst = 1'b1;
    #1;
    chk_reset_state("midreset");
    q.delete();
    last = '0;
    step(); step();
    chk_reset_state("midreset_held");
    tb_rst = 1'b0;
    step();

    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 8; k++) w[32*k +: 32] = $urandom;
      wr_en = 1'b1; wr_data = w;
      push_word(w);
      step();
    end
    wr_en = 1'b0;
    repeat (5) step();
    chk_settled("post_reset_fill");
    for (int i = 0; i < 96; i++) begin
      rd_en = 1'b1;
      last = q.pop_front();
      step();
      chk("post_reset_rd_data", rd_data, last);
    end
    rd_en = 1'b0;
    repeat (6) step();
    chk_settled("post_reset_drain");
    chk("post_reset_almost_empty", almost_empty, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
